// File: rtl/traffic_eval_egress_checker.sv
`default_nettype none
// ============================================================================
// traffic_eval_egress_checker : egress flit sink with deterministic
// backpressure, framing/order checks and sticky pass/fail reporting. Rev 1.0
// ============================================================================
module traffic_eval_egress_checker #(
   parameter int unsigned EGRESS_ID        = 0,
   parameter int unsigned N_INGRESSES      = 4,
   parameter int unsigned EXPECTED_PACKETS = 16,
   parameter int unsigned MAX_PACKET_FLITS = 8,
   parameter int unsigned STALL_EVERY      = 0,
   parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
   input  logic        clock,
   input  logic        reset,
   output logic        flit_in_ready,
   input  logic        flit_in_valid,
   input  logic        flit_in_head,
   input  logic        flit_in_tail,
   input  logic [63:0] flit_in_ingress_id,
   input  logic [63:0] flit_in_unique_id,
   output logic [31:0] packets_received,
   output logic [3:0]  error_code,
   output logic        success,
   output logic        fatal
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_IN_PKT = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [1:0] ST_FATAL  = 2'd3;
   localparam int IDX_W = (N_INGRESSES > 1) ? $clog2(N_INGRESSES) : 1;

   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic [3:0]             err;
   logic                   accept;
   logic                   active;
   logic                   stall_hit;
   logic                   in_range;
   logic [IDX_W-1:0]       idx;
   logic [31:0]            idle_cnt;
   logic [31:0]            flit_cnt;
   logic [31:0]            pkts_inc;
   logic [63:0]            cur_ing;
   logic [63:0]            cur_uid;
   logic [N_INGRESSES-1:0] seen;
   logic [63:0]            last_uid [N_INGRESSES];

   assign accept   = flit_in_valid && flit_in_ready;
   assign active   = (state == ST_IDLE) || (state == ST_IN_PKT);
   assign in_range = flit_in_ingress_id < 64'(N_INGRESSES);
   assign idx      = flit_in_ingress_id[IDX_W-1:0];
   assign pkts_inc = (packets_received == 32'hFFFF_FFFF) ? packets_received
                                                          : packets_received + 32'd1;

   generate
      if (STALL_EVERY == 0) begin : g_no_stall
         assign stall_hit = 1'b0;
      end else begin : g_stall
         logic [31:0] stall_cnt;
         always_ff @(posedge clock or negedge reset) begin
            if (!reset)
               stall_cnt <= 32'd0;
            else if (stall_cnt == STALL_EVERY - 1)
               stall_cnt <= 32'd0;
            else
               stall_cnt <= stall_cnt + 32'd1;
         end
         assign stall_hit = (stall_cnt == STALL_EVERY - 1);
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Flit errors take priority over the timeout because a timeout needs !accept.
   always_comb begin
      err       = 4'd0;
      state_nxt = state;
      if (accept && state == ST_DONE)
         err = 4'd8;
      else if (accept && active) begin
         if (state == ST_IDLE && !flit_in_head)
            err = 4'd1;
         else if (state == ST_IN_PKT && flit_in_head)
            err = 4'd2;
         else if (state == ST_IN_PKT &&
                  (flit_in_ingress_id != cur_ing || flit_in_unique_id != cur_uid))
            err = 4'd3;
         else if (flit_in_head && !in_range)
            err = 4'd4;
         else if (flit_in_head && seen[idx] && flit_in_unique_id <= last_uid[idx])
            err = 4'd5;
         else if (!flit_in_head && flit_cnt >= MAX_PACKET_FLITS)
            err = 4'd6;
      end else if (!accept && active && idle_cnt == TIMEOUT_CYCLES - 1)
         err = 4'd7;

      if (err != 4'd0)
         state_nxt = ST_FATAL;
      else if (accept && active) begin
         if (!flit_in_tail)
            state_nxt = ST_IN_PKT;
         else if (pkts_inc == EXPECTED_PACKETS)
            state_nxt = ST_DONE;
         else
            state_nxt = ST_IDLE;
      end
   end

   always_comb begin
      success = (state == ST_DONE);
      fatal   = (state == ST_FATAL);
   end

   // Ready follows the current state, so it stays up for the first DONE cycle:
   // a trailing flit offered right after the final tail is caught as code 8.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         flit_in_ready    <= 1'b0;
         error_code       <= 4'd0;
         packets_received <= 32'd0;
         idle_cnt         <= 32'd0;
         flit_cnt         <= 32'd0;
         cur_ing          <= 64'd0;
         cur_uid          <= 64'd0;
         seen             <= '0;
      end else begin
         flit_in_ready <= active && !stall_hit;
         if (err != 4'd0)
            error_code <= err;
         if (accept)
            idle_cnt <= 32'd0;
         else if (active)
            idle_cnt <= idle_cnt + 32'd1;
         if (accept && active && err == 4'd0) begin
            if (flit_in_tail)
               packets_received <= pkts_inc;
            if (flit_in_head) begin
               cur_ing     <= flit_in_ingress_id;
               cur_uid     <= flit_in_unique_id;
               flit_cnt    <= 32'd1;
               seen[idx]   <= 1'b1;
            end else begin
               flit_cnt <= flit_cnt + 32'd1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept && active && err == 4'd0 && flit_in_head)
         last_uid[idx] <= flit_in_unique_id;
   end

endmodule
`default_nettype wire
